// File: rtl/path_replay_ctrl_if.sv
// Stack read port, replay request/status and motion handshake of the path replay controller.
interface path_replay_ctrl_if #(
  parameter int unsigned AW = 8
);
  logic          run;
  logic          solved;
  logic [AW:0]   stkCnt;
  logic [AW-1:0] stkRdAddr;
  logic [1:0]    stkData;
  logic          move;
  logic [1:0]    dir;
  logic          mvReady;
  logic [7:0]    loc;
  logic          busy;
  logic          finished;
  logic          err;

  // Controller side
  modport master (
    input  run, solved, stkCnt, stkData, mvReady,
    output stkRdAddr, move, dir, loc, busy, finished, err
  );

  // Solver / stack / motion side
  modport slave (
    output run, solved, stkCnt, stkData, mvReady,
    input  stkRdAddr, move, dir, loc, busy, finished, err
  );
endinterface

// File: rtl/path_replay_ctrl.sv
// Replays the solved path: walks the backtrack stack bottom-up, offers one
// direction per step over move/mvReady, tracks the rat on the 16x16 grid and
// flags off-grid steps or a walk that does not end on the goal cell.
module path_replay_ctrl #(
  parameter int unsigned AW        = 8,
  parameter logic [7:0]  START_LOC = 8'h00,
  parameter logic [7:0]  GOAL_LOC  = 8'hFF
) (
  input  logic               clk,
  input  logic               rst,
  path_replay_ctrl_if.master bus
);

  localparam int unsigned CW = AW + 1;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_CAPT  = 3'd2,
    ST_OFFER = 3'd3,
    ST_CHECK = 3'd4,
    ST_FAIL  = 3'd5
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_idx;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_addr;
  logic [1:0]    r_dir;
  logic          r_move;
  logic [7:0]    r_loc;
  logic          r_busy;
  logic          r_fin;
  logic          r_err;

  state_t        w_nxt_state;
  logic [CW-1:0] w_nxt_idx;
  logic [CW-1:0] w_nxt_cnt;
  logic [AW-1:0] w_nxt_addr;
  logic [1:0]    w_nxt_dir;
  logic          w_nxt_move;
  logic [7:0]    w_nxt_loc;
  logic          w_nxt_fin;
  logic          w_nxt_err;

  logic [CW-1:0] w_idx_inc;
  logic          w_off_grid;
  logic [7:0]    w_loc_step;

  // Index is AW+1 bits wide so a full stack (2^AW entries) terminates without wrap.
  assign w_idx_inc = r_idx + CW'(1);

  // Bounds check of the freshly read stack entry against the current cell.
  always_comb begin
    w_off_grid = 1'b0;
    case (bus.stkData)
      DIR_UP:    w_off_grid = (r_loc[7:4] == 4'd0);
      DIR_RIGHT: w_off_grid = (r_loc[3:0] == 4'd15);
      DIR_DOWN:  w_off_grid = (r_loc[7:4] == 4'd15);
      DIR_LEFT:  w_off_grid = (r_loc[3:0] == 4'd0);
      default:   w_off_grid = 1'b0;
    endcase
  end

  // Cell reached by taking the offered step; bounds were checked in CAPT.
  always_comb begin
    w_loc_step = r_loc;
    case (r_dir)
      DIR_UP:    w_loc_step[7:4] = r_loc[7:4] - 4'd1;
      DIR_RIGHT: w_loc_step[3:0] = r_loc[3:0] + 4'd1;
      DIR_DOWN:  w_loc_step[7:4] = r_loc[7:4] + 4'd1;
      DIR_LEFT:  w_loc_step[3:0] = r_loc[3:0] - 4'd1;
      default:   w_loc_step      = r_loc;
    endcase
  end

  // Next-state and next-output logic; all outputs are registered from these.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_idx   = r_idx;
    w_nxt_cnt   = r_cnt;
    w_nxt_addr  = r_addr;
    w_nxt_dir   = r_dir;
    w_nxt_move  = 1'b0;
    w_nxt_loc   = r_loc;
    w_nxt_fin   = 1'b0;
    w_nxt_err   = r_err;

    case (r_state)
      ST_IDLE: begin
        if (bus.run && bus.solved) begin
          w_nxt_cnt  = bus.stkCnt;
          w_nxt_idx  = '0;
          w_nxt_addr = '0;
          w_nxt_loc  = START_LOC;
          w_nxt_err  = 1'b0;
          w_nxt_state = (bus.stkCnt == '0) ? ST_CHECK : ST_FETCH;
        end
      end

      // Read address was loaded on entry, data arrives for CAPT.
      ST_FETCH: begin
        w_nxt_state = ST_CAPT;
      end

      ST_CAPT: begin
        w_nxt_dir = bus.stkData;
        if (w_off_grid) begin
          w_nxt_err   = 1'b1;
          w_nxt_state = ST_FAIL;
        end else begin
          w_nxt_move  = 1'b1;
          w_nxt_state = ST_OFFER;
        end
      end

      ST_OFFER: begin
        if (r_move && bus.mvReady) begin
          w_nxt_loc   = w_loc_step;
          w_nxt_idx   = w_idx_inc;
          w_nxt_addr  = w_idx_inc[AW-1:0];
          w_nxt_state = (w_idx_inc == r_cnt) ? ST_CHECK : ST_FETCH;
        end else begin
          w_nxt_move = 1'b1;
        end
      end

      ST_CHECK: begin
        if (r_loc == GOAL_LOC) begin
          w_nxt_fin   = 1'b1;
          w_nxt_state = ST_IDLE;
        end else begin
          w_nxt_err   = 1'b1;
          w_nxt_state = ST_FAIL;
        end
      end

      ST_FAIL: begin
        w_nxt_err   = 1'b1;
        w_nxt_state = ST_IDLE;
      end

      default: begin
        w_nxt_state = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_dir   <= 2'b00;
      r_move  <= 1'b0;
      r_loc   <= START_LOC;
      r_busy  <= 1'b0;
      r_fin   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_idx   <= w_nxt_idx;
      r_cnt   <= w_nxt_cnt;
      r_addr  <= w_nxt_addr;
      r_dir   <= w_nxt_dir;
      r_move  <= w_nxt_move;
      r_loc   <= w_nxt_loc;
      r_busy  <= (w_nxt_state != ST_IDLE);
      r_fin   <= w_nxt_fin;
      r_err   <= w_nxt_err;
    end
  end

  assign bus.stkRdAddr = r_addr;
  assign bus.move      = r_move;
  assign bus.dir       = r_dir;
  assign bus.loc       = r_loc;
  assign bus.busy      = r_busy;
  assign bus.finished  = r_fin;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_path_replay_ctrl.sv
// Bench for path_replay_ctrl: behavioural stack memory, grid model feeding a
// scoreboard of expected (dir, loc) steps, one task per scenario.
module tb_path_replay_ctrl;

  localparam int unsigned AW    = 8;
  localparam logic [7:0]  START = 8'h00;
  localparam logic [7:0]  GOAL  = 8'hFF;

  typedef struct packed {
    logic [1:0] dir;
    logic [7:0] loc;
  } step_t;

  logic clk = 1'b0;
  logic rst;

  path_replay_ctrl_if #(.AW(AW)) bus ();

  path_replay_ctrl #(.AW(AW), .START_LOC(START), .GOAL_LOC(GOAL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Synchronous 1-cycle stack read
  logic [1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) bus.stkData <= mem[bus.stkRdAddr];

  int n_checks = 0;
  int n_pass   = 0;

  logic [1:0] stk_q [$];
  step_t      exp_q [$];
  int         exp_moves;
  logic       exp_fin;
  logic       exp_err;
  logic [7:0] exp_loc;

  int   r_moves;
  int   r_cycles;
  int   r_bp_seen;
  logic r_fin;
  logic r_err;

  // Load the stack and derive the expected walk from a grid model
  task automatic prepare();
    logic [7:0] l;
    logic [3:0] row;
    logic [3:0] col;
    logic       off;
    bit         stop;
    step_t      s;
    exp_q.delete();
    l = START; exp_err = 1'b0; exp_fin = 1'b0; stop = 1'b0;
    for (int i = 0; i < stk_q.size(); i++) mem[i] = stk_q[i];
    bus.stkCnt = (AW+1)'(stk_q.size());
    for (int i = 0; i < stk_q.size() && !stop; i++) begin
      row = l[7:4]; col = l[3:0];
      case (stk_q[i])
        2'b00:   off = (row == 4'd0);
        2'b01:   off = (col == 4'd15);
        2'b10:   off = (row == 4'd15);
        default: off = (col == 4'd0);
      endcase
      if (off) begin
        exp_err = 1'b1;
        stop = 1'b1;
      end else begin
        s.dir = stk_q[i]; s.loc = l;
        exp_q.push_back(s);
        case (stk_q[i])
          2'b00:   row = row - 4'd1;
          2'b01:   col = col + 4'd1;
          2'b10:   row = row + 4'd1;
          default: col = col - 4'd1;
        endcase
        l = {row, col};
      end
    end
    exp_moves = exp_q.size();
    exp_loc = l;
    if (!exp_err) begin
      exp_fin = (l == GOAL);
      exp_err = ~exp_fin;
    end
  endtask

  // Issue run, consume steps against the scoreboard until busy falls
  task automatic run_replay(input int bp_step, input int bp_len, input bit pulse_mid);
    step_t e;
    int    hold;
    bit    seen_busy, done, pulsed;
    hold = 0; seen_busy = 0; done = 0; pulsed = 0;
    r_moves = 0; r_cycles = 0; r_bp_seen = 0; r_fin = 1'b0; r_err = 1'b0;
    bus.mvReady = 1'b1;
    bus.run = 1'b1; bus.solved = 1'b1;
    for (int c = 0; c < 4000 && !done; c++) begin
      @(negedge clk);
      bus.run = 1'b0; bus.solved = 1'b0;
      if (c == 0) bus.stkCnt = (AW+1)'($urandom);
      if (!seen_busy) begin
        if (bus.busy) begin
          seen_busy = 1'b1;
          n_checks++;
          if (bus.err !== 1'b0) $display("FAIL err_clear_on_run: got %b want 0", bus.err);
          else n_pass++;
        end
      end else if (!bus.busy) begin
        done = 1'b1; r_cycles = c + 1; r_fin = bus.finished; r_err = bus.err;
      end
      if (!done && bus.move) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_move: got dir=%b loc=%h want no move", bus.dir, bus.loc);
        end else begin
          e = exp_q[0];
          if (bus.dir !== e.dir || bus.loc !== e.loc)
            $display("FAIL step%0d: got dir=%b loc=%h want dir=%b loc=%h",
                     r_moves, bus.dir, bus.loc, e.dir, e.loc);
          else n_pass++;
          if (r_moves == bp_step) r_bp_seen++;
          if (r_moves == bp_step && hold < bp_len) begin
            bus.mvReady = 1'b0; hold++;
          end else begin
            bus.mvReady = 1'b1;
            void'(exp_q.pop_front());
            r_moves++;
          end
        end
      end
      if (!done && pulse_mid && !pulsed && r_moves == 5) begin
        bus.run = 1'b1; bus.solved = 1'b1; pulsed = 1'b1;
      end
    end
    if (!done) begin
      n_checks++;
      $display("FAIL timeout: busy=%b after 4000 cycles want 0", bus.busy);
    end
  endtask

  task automatic fill_happy();
    stk_q.delete();
    for (int i = 0; i < 15; i++) stk_q.push_back(2'b01);
    for (int i = 0; i < 15; i++) stk_q.push_back(2'b10);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.busy); else n_pass++;
    n_checks++; if (bus.move !== 1'b0) $display("FAIL rst_move: got %b want 0", bus.move); else n_pass++;
    n_checks++; if (bus.loc !== START) $display("FAIL rst_loc: got %h want %h", bus.loc, START); else n_pass++;
    n_checks++; if (bus.err !== 1'b0 || bus.finished !== 1'b0)
      $display("FAIL rst_flags: got err=%b fin=%b want 0/0", bus.err, bus.finished); else n_pass++;
    n_checks++; if (bus.dir !== 2'b00 || bus.stkRdAddr !== 8'h00)
      $display("FAIL rst_dir_addr: got %b/%h want 00/00", bus.dir, bus.stkRdAddr); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_offer();
    int  acc;
    bit  hit;
    acc = 0; hit = 0;
    fill_happy(); prepare();
    bus.mvReady = 1'b1; bus.run = 1'b1; bus.solved = 1'b1;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clk);
      bus.run = 1'b0; bus.solved = 1'b0;
      if (bus.move) begin
        if (acc == 3) hit = 1'b1;
        else acc++;
      end
    end
    n_checks++;
    if (!hit || bus.loc !== 8'h03) $display("FAIL pre_rst_offer: got move=%b loc=%h want 1/03", bus.move, bus.loc);
    else n_pass++;
    bus.mvReady = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.mvReady = 1'b1;
    n_checks++; if (bus.move !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL midrst_move_busy: got %b/%b want 0/0", bus.move, bus.busy); else n_pass++;
    n_checks++; if (bus.loc !== START || bus.err !== 1'b0)
      $display("FAIL midrst_loc_err: got %h/%b want %h/0", bus.loc, bus.err, START); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.move !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL midrst_idle: got move=%b busy=%b want 0/0", bus.move, bus.busy); else n_pass++;
    exp_q.delete();
  endtask

  task automatic check_end(input string tag);
    n_checks++; if (r_moves !== exp_moves) $display("FAIL %s_moves: got %0d want %0d", tag, r_moves, exp_moves); else n_pass++;
    n_checks++; if (r_fin !== exp_fin) $display("FAIL %s_finished: got %b want %b", tag, r_fin, exp_fin); else n_pass++;
    n_checks++; if (r_err !== exp_err) $display("FAIL %s_err: got %b want %b", tag, r_err, exp_err); else n_pass++;
    n_checks++; if (bus.loc !== exp_loc) $display("FAIL %s_loc: got %h want %h", tag, bus.loc, exp_loc); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.finished !== 1'b0 || bus.loc !== exp_loc)
      $display("FAIL %s_after: got fin=%b loc=%h want 0/%h", tag, bus.finished, bus.loc, exp_loc); else n_pass++;
  endtask

  task automatic test_happy();
    fill_happy(); prepare();
    run_replay(-1, 0, 1'b0);
    check_end("happy");
  endtask

  task automatic test_backpressure();
    fill_happy(); prepare();
    run_replay(3, 4, 1'b0);
    n_checks++; if (r_bp_seen !== 5) $display("FAIL bp_hold_cycles: got %0d want 5", r_bp_seen); else n_pass++;
    check_end("bp");
  endtask

  task automatic test_off_grid();
    stk_q.delete();
    stk_q.push_back(2'b00); stk_q.push_back(2'b01); stk_q.push_back(2'b01);
    stk_q.push_back(2'b10); stk_q.push_back(2'b10);
    prepare();
    run_replay(-1, 0, 1'b0);
    n_checks++; if (r_cycles !== 4) $display("FAIL offgrid_busy_len: got %0d want 4", r_cycles); else n_pass++;
    check_end("offgrid");
  endtask

  task automatic test_wrong_end();
    stk_q.delete();
    stk_q.push_back(2'b01); stk_q.push_back(2'b10);
    prepare();
    run_replay(-1, 0, 1'b0);
    check_end("wrongend");
  endtask

  task automatic test_empty();
    stk_q.delete();
    prepare();
    run_replay(-1, 0, 1'b0);
    n_checks++; if (r_cycles !== 3) $display("FAIL empty_busy_len: got %0d want 3", r_cycles); else n_pass++;
    check_end("empty");
  endtask

  task automatic test_gating();
    for (int i = 0; i < 5; i++) begin
      bus.run = 1'b1; bus.solved = 1'b0;
      @(negedge clk);
      n_checks++; if (bus.busy !== 1'b0) $display("FAIL gate_unsolved%0d: got busy=%b want 0", i, bus.busy); else n_pass++;
    end
    bus.run = 1'b0;
    fill_happy(); prepare();
    run_replay(-1, 0, 1'b1);
    check_end("runbusy");
  endtask

  task automatic test_full_stack();
    fill_happy();
    for (int i = 0; i < 113; i++) begin
      stk_q.push_back(2'b11); stk_q.push_back(2'b01);
    end
    prepare();
    run_replay(-1, 0, 1'b0);
    check_end("full");
  endtask

  initial begin
    bus.run = 1'b0; bus.solved = 1'b0; bus.mvReady = 1'b1; bus.stkCnt = '0;
    for (int i = 0; i < (1<<AW); i++) mem[i] = 2'b00;
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_happy();
    test_backpressure();
    test_off_grid();
    test_reset_mid_offer();
    test_wrong_end();
    test_empty();
    test_gating();
    test_full_stack();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
